// File: rtl/mmu09_io_pkg.sv
// Shared register map, control/status bit positions and counter width for
// the mmu09 I/O slots.
package mmu09_io_pkg;

    localparam int unsigned CountW = 16;

    localparam logic [2:0] RegReloadLo = 3'd0;
    localparam logic [2:0] RegReloadHi = 3'd1;
    localparam logic [2:0] RegCtrl     = 3'd2;
    localparam logic [2:0] RegStatus   = 3'd3;
    localparam logic [2:0] RegCountLo  = 3'd4;
    localparam logic [2:0] RegCountHi  = 3'd5;

    localparam int unsigned CtrlEnBit      = 0;
    localparam int unsigned CtrlIeBit      = 1;
    localparam int unsigned CtrlOneshotBit = 2;
    localparam int unsigned StatusExpBit   = 0;

endpackage

// File: rtl/tick_counter.sv
// 16-bit down counter with reload on zero and a single-cycle expiry pulse.
module tick_counter
    import mmu09_io_pkg::*;
(
    input  logic              i_eclk,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_load,
    input  logic [CountW-1:0] i_load_val,
    input  logic [CountW-1:0] i_reload_val,
    output logic [CountW-1:0] o_count,
    output logic              o_expire
);

    logic [CountW-1:0] r_count;
    logic [CountW-1:0] w_count_next;

    assign o_expire = i_en && (r_count == '0);
    assign o_count  = r_count;

    // A direct load from the bus beats both reload and decrement.
    always_comb begin
        w_count_next = r_count;
        if (i_load) begin
            w_count_next = i_load_val;
        end else if (o_expire) begin
            w_count_next = i_reload_val;
        end else if (i_en) begin
            w_count_next = r_count - CountW'(1);
        end
    end

    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

endmodule

// File: rtl/io_tick_timer.sv
// Memory-mapped periodic / one-shot tick timer for a 6809 I/O slot: register
// file and bus interface around a tick_counter.
module io_tick_timer
    import mmu09_io_pkg::*;
(
    input  logic       i_eclk,
    input  logic       i_reset,
    input  logic       i_sel,
    input  logic       i_rw,
    input  logic [2:0] i_addr,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_data_oe,
    output logic       o_irq_n
);

    logic [7:0]        r_reload_lo, r_reload_hi, r_shadow;
    logic [2:0]        r_ctrl;
    logic              r_exp;
    logic [7:0]        w_reload_lo, w_reload_hi, w_shadow;
    logic [2:0]        w_ctrl;
    logic              w_exp;
    logic              w_wr, w_rd, w_load, w_expire;
    logic [CountW-1:0] w_count;

    assign w_wr   = i_sel && !i_rw;
    assign w_rd   = i_sel && i_rw;
    assign w_load = w_wr && (i_addr == RegReloadHi);

    tick_counter u_tick_counter (
        .i_eclk       (i_eclk),
        .i_reset      (i_reset),
        .i_en         (r_ctrl[CtrlEnBit]),
        .i_load       (w_load),
        .i_load_val   ({i_data, r_reload_lo}),
        .i_reload_val ({r_reload_hi, r_reload_lo}),
        .o_count      (w_count),
        .o_expire     (w_expire)
    );

    always_comb begin
        w_reload_lo = r_reload_lo;
        w_reload_hi = r_reload_hi;
        w_ctrl      = r_ctrl;
        w_exp       = r_exp;
        w_shadow    = r_shadow;
        if (w_wr) begin
            case (i_addr)
                RegReloadLo: w_reload_lo = i_data;
                RegReloadHi: w_reload_hi = i_data;
                RegCtrl:     w_ctrl      = i_data[2:0];
                RegStatus:   if (i_data[StatusExpBit]) w_exp = 1'b0;
                default:     ;
            endcase
        end
        if (w_rd && (i_addr == RegCountHi)) begin
            w_shadow = w_count[7:0];
        end
        // Expiry is applied last so it wins over a same-edge clear or CTRL write.
        if (w_expire) begin
            w_exp = 1'b1;
            if (r_ctrl[CtrlOneshotBit]) w_ctrl[CtrlEnBit] = 1'b0;
        end
    end

    always_ff @(posedge i_eclk) begin
        if (!i_reset) begin
            r_reload_lo <= '0;
            r_reload_hi <= '0;
            r_ctrl      <= '0;
            r_exp       <= 1'b0;
            r_shadow    <= '0;
        end else begin
            r_reload_lo <= w_reload_lo;
            r_reload_hi <= w_reload_hi;
            r_ctrl      <= w_ctrl;
            r_exp       <= w_exp;
            r_shadow    <= w_shadow;
        end
    end

    always_comb begin
        o_data = 8'h00;
        case (i_addr)
            RegReloadLo: o_data = r_reload_lo;
            RegReloadHi: o_data = r_reload_hi;
            RegCtrl:     o_data = {5'b0, r_ctrl};
            RegStatus:   o_data = {7'b0, r_exp};
            RegCountLo:  o_data = r_shadow;
            RegCountHi:  o_data = w_count[15:8];
            default:     o_data = 8'h00;
        endcase
    end

    assign o_data_oe = i_sel && i_rw && i_eclk;
    assign o_irq_n   = !(r_exp && r_ctrl[CtrlIeBit]);

endmodule
